// File: rtl/mem_resp_pkg.sv
// Shared definitions for the backing-memory responder and the cache that talks to it.
// Holds the FSM state encoding and the default geometry/latency constants.
package mem_resp_pkg;

   localparam int MEM_ADDR_W  = 5;
   localparam int MEM_DATA_W  = 8;
   localparam int MEM_LATENCY = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/mem_resp_array.sv
// Main-memory storage: synchronous write, registered read; rdata holds until the next read.
// MEM_RESPONDER_INIT_EN: reset loads every word with its own address, otherwise storage has no reset.
module mem_resp_array
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

`ifdef MEM_RESPONDER_INIT_EN
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= DATA_W'(i);
         end
      end else if (wr_en) begin
         mem[addr] <= wdata;
      end
   end
`else
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[addr] <= wdata;
      end
   end
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rdata <= '0;
      end else if (rd_en) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: req/ack handshake, ack LATENCY cycles after acceptance.
// No queuing; requester holds req until ack, dropping it early aborts. Array init via MEM_RESPONDER_INIT_EN.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int DATA_W  = MEM_DATA_W,
   parameter int LATENCY = MEM_LATENCY
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              req,
   input  logic              wren,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic              ack,
   output logic              busy,
   output logic [DATA_W-1:0] data_out
);

   generate
      if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
         $error("mem_responder: LATENCY must be in 1..15");
      end
   endgenerate

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_t            state, state_n;
   logic [3:0]        cnt, cnt_n;
   logic              wren_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              commit;
   logic              c_wren;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_data;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         cnt    <= '0;
         wren_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (state == IDLE && req) begin
            wren_q <= wren;
            addr_q <= addr;
            data_q <= data_in;
         end
      end
   end

   // WAIT lasts LATENCY-1 cycles: leave when the decrement would land on zero.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      commit  = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (LATENCY == 1) begin
                  state_n = RESP;
                  cnt_n   = '0;
                  commit  = 1'b1;
               end else begin
                  state_n = WAIT;
                  cnt_n   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (!req) begin
               state_n = IDLE;
            end else begin
               cnt_n = cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state_n = RESP;
                  commit  = 1'b1;
               end
            end
         end
         RESP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // With LATENCY=1 the commit happens on the acceptance edge, before capture lands.
   always_comb begin
      c_wren = wren_q;
      c_addr = addr_q;
      c_data = data_q;
      if (state == IDLE) begin
         c_wren = wren;
         c_addr = addr;
         c_data = data_in;
      end
   end

   mem_resp_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clock  (clock),
      .resetn (resetn),
      .wr_en  (commit & c_wren),
      .rd_en  (commit & ~c_wren),
      .addr   (c_addr),
      .wdata  (c_data),
      .rdata  (data_out)
   );

   assign ack  = (state == RESP);
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: LATENCY=3 instance for the main scenarios, LATENCY=1 instance for back-to-back.
// Expected data comes from a word-array model of main memory plus the last completed read.
module tb_mem_responder;

   localparam int L = 3;

   logic       clock = 1'b0;
   always #5 clock = ~clock;

   logic       resetn, req, wren, ack, busy;
   logic [4:0] addr;
   logic [7:0] data_in, data_out;

   logic       resetn_b, req_b, wren_b, ack_b, busy_b;
   logic [4:0] addr_b;
   logic [7:0] data_in_b, data_out_b;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] exp_mem [32];
   bit         known [32];
   logic [7:0] last_rd;
   bit         last_known;

   mem_responder #(.ADDR_W(5), .DATA_W(8), .LATENCY(L)) u_dut (
      .clock(clock), .resetn(resetn), .req(req), .wren(wren), .addr(addr),
      .data_in(data_in), .ack(ack), .busy(busy), .data_out(data_out)
   );

   mem_responder #(.ADDR_W(5), .DATA_W(8), .LATENCY(1)) u_dut_l1 (
      .clock(clock), .resetn(resetn_b), .req(req_b), .wren(wren_b), .addr(addr_b),
      .data_in(data_in_b), .ack(ack_b), .busy(busy_b), .data_out(data_out_b)
   );

   function automatic void model_reset();
      last_rd    = 8'h00;
      last_known = 1'b1;
`ifdef MEM_RESPONDER_INIT_EN
      for (int i = 0; i < 32; i++) begin
         exp_mem[i] = 8'(i);
         known[i]   = 1'b1;
      end
`endif
   endfunction

   // One full transaction on the LATENCY=3 instance; requester drops req on the edge it sees ack.
   task automatic run_txn(input logic w, input logic [4:0] a, input logic [7:0] d, input bit scramble);
      logic [7:0] exp_d;
      bit         chk_d;
      if (w) begin
         exp_d = last_rd;
         chk_d = last_known;
      end else begin
         exp_d = exp_mem[a];
         chk_d = known[a];
      end
      @(posedge clock);
      #1 req = 1'b1; wren = w; addr = a; data_in = d;
      @(posedge clock);
      for (int k = 1; k <= L + 1; k++) begin
         @(negedge clock);
         vectors++;
         if (ack !== (k == L)) begin
            miscompares++;
            $display("FAIL txn_ack addr=%0d k=%0d: got %b want %b", a, k, ack, (k == L));
         end
         vectors++;
         if (busy !== (k <= L)) begin
            miscompares++;
            $display("FAIL txn_busy addr=%0d k=%0d: got %b want %b", a, k, busy, (k <= L));
         end
         if (k == L && chk_d) begin
            vectors++;
            if (data_out !== exp_d) begin
               miscompares++;
               $display("FAIL txn_data %s addr=%0d: got %h want %h", w ? "wr" : "rd", a, data_out, exp_d);
            end
         end
         @(posedge clock);
         if (k == 1 && scramble) begin
            #1 addr = ~a; data_in = ~d; wren = ~w;
         end
         if (k == L) begin
            #1 req = 1'b0;
         end
      end
      if (w) begin
         exp_mem[a] = d;
         known[a]   = 1'b1;
      end else begin
         last_rd    = exp_d;
         last_known = chk_d;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; req = 1'b0; wren = 1'b0; addr = '0; data_in = '0;
      resetn_b = 1'b0; req_b = 1'b0; wren_b = 1'b0; addr_b = '0; data_in_b = '0;
      for (int i = 0; i < 32; i++) begin
         known[i] = 1'b0;
      end
      repeat (3) @(negedge clock);
      vectors++;
      if ({ack, busy, data_out} !== 10'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got ack=%b busy=%b data=%h want 0", ack, busy, data_out);
      end
      vectors++;
      if ({ack_b, busy_b, data_out_b} !== 10'h0) begin
         miscompares++;
         $display("FAIL reset_outputs_l1: got ack=%b busy=%b data=%h want 0", ack_b, busy_b, data_out_b);
      end
      resetn = 1'b1;
      resetn_b = 1'b1;
      model_reset();
      @(negedge clock);
      vectors++;
      if ({ack, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL idle_after_reset: got ack=%b busy=%b want 00", ack, busy);
      end
   endtask

   task automatic test_write_read();
`ifndef MEM_RESPONDER_INIT_EN
      run_txn(1'b1, 5'd17, 8'h11, 1'b0);
`endif
      run_txn(1'b0, 5'd17, 8'h00, 1'b0);
      run_txn(1'b1, 5'd9, 8'hA5, 1'b0);
      run_txn(1'b0, 5'd9, 8'h00, 1'b0);
   endtask

   task automatic test_capture();
      run_txn(1'b1, 5'd10, 8'h5A, 1'b0);
      run_txn(1'b1, 5'd3, 8'h3C, 1'b1);
      run_txn(1'b0, 5'd3, 8'h00, 1'b0);
      run_txn(1'b0, 5'd10, 8'h00, 1'b0);
   endtask

   task automatic test_abort();
`ifndef MEM_RESPONDER_INIT_EN
      run_txn(1'b1, 5'd4, 8'h44, 1'b0);
`endif
      @(posedge clock);
      #1 req = 1'b1; wren = 1'b1; addr = 5'd4; data_in = 8'h77;
      @(posedge clock);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         vectors++;
         if (ack !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_ack k=%0d: got %b want 0", k, ack);
         end
         vectors++;
         if (busy !== (k <= 2)) begin
            miscompares++;
            $display("FAIL abort_busy k=%0d: got %b want %b", k, busy, (k <= 2));
         end
         @(posedge clock);
         if (k == 1) begin
            #1 req = 1'b0;
         end
      end
      run_txn(1'b0, 5'd4, 8'h00, 1'b0);
   endtask

   task automatic test_reset_mid();
      run_txn(1'b1, 5'd12, 8'h3C, 1'b0);
      run_txn(1'b0, 5'd12, 8'h00, 1'b0);
      @(posedge clock);
      #1 req = 1'b1; wren = 1'b1; addr = 5'd12; data_in = 8'hC3;
      @(posedge clock);
      @(posedge clock);
      #1 resetn = 1'b0; req = 1'b0;
      #1;
      vectors++;
      if ({ack, busy, data_out} !== 10'h0) begin
         miscompares++;
         $display("FAIL async_reset: got ack=%b busy=%b data=%h want 0", ack, busy, data_out);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         vectors++;
         if (ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_ack k=%0d: got %b want 0", k, ack);
         end
      end
      resetn = 1'b1;
      model_reset();
      run_txn(1'b0, 5'd12, 8'h00, 1'b0);
   endtask

   task automatic test_random();
      logic       w;
      logic [4:0] a;
      logic [7:0] d;
      for (int n = 0; n < 30; n++) begin
         w = 1'($urandom_range(0, 1));
         a = 5'($urandom_range(0, 31));
         d = 8'($urandom);
         run_txn(w, a, d, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(posedge clock);
      end
   endtask

   // LATENCY=1 pair with req held across the first ack; the second request is accepted from IDLE.
   task automatic l1_pair(input logic w, input logic [7:0] d0, input logic [7:0] d1);
      logic [7:0] e0, e1;
      e0 = w ? 8'h00 : d0;
      e1 = w ? 8'h00 : d1;
      @(posedge clock);
      #1 req_b = 1'b1; wren_b = w; addr_b = 5'd0; data_in_b = d0;
      @(posedge clock);
      @(negedge clock);
      vectors++;
      if (ack_b !== 1'b1 || data_out_b !== e0) begin
         miscompares++;
         $display("FAIL b2b_first w=%b: got ack=%b data=%h want ack=1 data=%h", w, ack_b, data_out_b, e0);
      end
      @(posedge clock);
      #1 addr_b = 5'd31; data_in_b = d1;
      @(negedge clock);
      vectors++;
      if (ack_b !== 1'b0 || busy_b !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_gap w=%b: got ack=%b busy=%b want 00", w, ack_b, busy_b);
      end
      @(negedge clock);
      vectors++;
      if (ack_b !== 1'b1 || data_out_b !== e1) begin
         miscompares++;
         $display("FAIL b2b_second w=%b: got ack=%b data=%h want ack=1 data=%h", w, ack_b, data_out_b, e1);
      end
      @(posedge clock);
      #1 req_b = 1'b0;
      @(negedge clock);
      vectors++;
      if (ack_b !== 1'b0 || busy_b !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_end w=%b: got ack=%b busy=%b want 00", w, ack_b, busy_b);
      end
   endtask

   task automatic test_back_to_back();
      l1_pair(1'b1, 8'h00, 8'h1F);
      l1_pair(1'b0, 8'h00, 8'h1F);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_capture();
      test_abort();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
